mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 4x4 array multiplier (8-bit product) between two requesters. It captures the winning requester's operands into registers that drive the shared multiplier. It waits a programmable settle time for the ripple-carry array, then latches the product into that requester's result register and holds it until the requester acknowledges. It sits between the switch/input logic and the single multiplier instance, so two operand sources no longer need two multiplier arrays.

---
 rtl/mul_arbiter.sv | 153 +++++++++++++++
 tb/tb_mul_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter/sequencer sharing one combinational 4x4
// array multiplier between two requesters.
//
// Ports:
//   Clock, Resetn      system clock, asynchronous active-low reset
//   req0/req1          operation requests
//   a0/b0, a1/b1       4-bit unsigned operands per requester
//   ack0/ack1          requester has consumed its result
//   gnt0/gnt1          one-cycle grant pulse (operands captured)
//   done0/done1        result valid in p0/p1, held until acknowledged
//   p0/p1              8-bit registered products
//   busy               multiply in progress
//   mA/mB              registered operands driving the shared multiplier
//   mP                 product returned by the shared multiplier
module mul_arbiter #(
    parameter int unsigned MUL_CYCLES = 1
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic       ack0,
    input  logic       ack1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] p0,
    output logic [7:0] p1,
    output logic       busy,
    output logic [3:0] mA,
    output logic [3:0] mB,
    input  logic [7:0] mP
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned P_W   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic [OP_W-1:0]  ma_d, mb_d;
    logic [P_W-1:0]   p0_d, p1_d;
    logic             done0_d, done1_d;
    logic             gnt0_d, gnt1_d;
    logic             busy_d;
    logic             elig0, elig1, win1;

    // A requester holding an unacknowledged result is not eligible.
    assign elig0 = req0 & ~done0;
    assign elig1 = req1 & ~done1;
    // Requester 1 wins when it is the only eligible one, or on a tie when the pointer names it.
    assign win1  = elig1 & (~elig0 | ptr_q);

    // State and output registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            mA      <= '0;
            mB      <= '0;
            p0      <= '0;
            p1      <= '0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            mA      <= ma_d;
            mB      <= mb_d;
            p0      <= p0_d;
            p1      <= p1_d;
            done0   <= done0_d;
            done1   <= done1_d;
            gnt0    <= gnt0_d;
            gnt1    <= gnt1_d;
            busy    <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        ma_d    = mA;
        mb_d    = mB;
        p0_d    = p0;
        p1_d    = p1;
        done0_d = done0;
        done1_d = done1;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = busy;

        // Acknowledge works in any state; ignored when no result is pending.
        if (ack0 && done0) done0_d = 1'b0;
        if (ack1 && done1) done1_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    ma_d    = win1 ? a1 : a0;
                    mb_d    = win1 ? b1 : b0;
                    gnt0_d  = ~win1;
                    gnt1_d  = win1;
                    owner_d = win1;
                    ptr_d   = ~win1;
                    cnt_d   = CNT_W'(MUL_CYCLES - 1);
                    busy_d  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                // Operands stay on mA/mB while the array settles.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (owner_q) begin
                        p1_d    = mP;
                        done1_d = 1'b1;
                    end else begin
                        p0_d    = mP;
                        done0_d = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter: one instance with a single
// settle cycle and one with three, each driving a behavioural multiplier.
module tb_mul_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, req0_s, req1_s;
    logic [3:0] a0, b0, a1, b1;
    logic       ack0, ack1;

    logic       gnt0, gnt1, done0, done1, busy;
    logic [7:0] p0, p1, mp;
    logic [3:0] ma, mb;

    logic       gnt0_s, gnt1_s, done0_s, done1_s, busy_s;
    logic [7:0] p0_s, p1_s, mp_s;
    logic [3:0] ma_s, mb_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Shared array multipliers seen by each instance.
    assign mp   = {4'b0, ma} * {4'b0, mb};
    assign mp_s = {4'b0, ma_s} * {4'b0, mb_s};

    mul_arbiter #(.MUL_CYCLES(1)) dut1 (
        .Clock(clk), .Resetn(rst_n),
        .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .p0(p0), .p1(p1), .busy(busy),
        .mA(ma), .mB(mb), .mP(mp)
    );

    mul_arbiter #(.MUL_CYCLES(3)) dut3 (
        .Clock(clk), .Resetn(rst_n),
        .req0(req0_s), .req1(req1_s), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .gnt0(gnt0_s), .gnt1(gnt1_s),
        .done0(done0_s), .done1(done1_s), .p0(p0_s), .p1(p1_s), .busy(busy_s),
        .mA(ma_s), .mB(mb_s), .mP(mp_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {req0, req1, req0_s, req1_s, ack0, ack1} = '0;
        {a0, b0, a1, b1} = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gnt0, gnt1, done0, done1, busy, ma, mb, p0, p1} !== 29'd0) begin
            errors++;
            $display("FAIL reset_dut1: got %h expected 0", {gnt0, gnt1, done0, done1, busy, ma, mb, p0, p1});
        end
        checks++;
        if ({gnt0_s, gnt1_s, done0_s, done1_s, busy_s, ma_s, mb_s, p0_s, p1_s} !== 29'd0) begin
            errors++;
            $display("FAIL reset_dut3: got %h expected 0", {gnt0_s, gnt1_s, done0_s, done1_s, busy_s, ma_s, mb_s, p0_s, p1_s});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            errors++;
            $display("FAIL idle_hold: gnt0/gnt1/busy got %b expected 000", {gnt0, gnt1, busy});
        end
    endtask

    task automatic test_single();
        a0 = 4'd7; b0 = 4'd9; req0 = 1'b1;
        step();
        checks++;
        if ({gnt0, gnt1, busy, done0, ma, mb} !== {4'b1010, 4'd7, 4'd9}) begin
            errors++;
            $display("FAIL single_grant: got %h expected %h", {gnt0, gnt1, busy, done0, ma, mb}, {4'b1010, 4'd7, 4'd9});
        end
        req0 = 1'b0;
        step();
        checks++;
        if ({gnt0, busy, done0, p0} !== {3'b001, 8'h3F}) begin
            errors++;
            $display("FAIL single_done: got %h expected %h", {gnt0, busy, done0, p0}, {3'b001, 8'h3F});
        end
        ack0 = 1'b1;
        step();
        ack0 = 1'b0;
        checks++;
        if ({done0, p0} !== {1'b0, 8'h3F}) begin
            errors++;
            $display("FAIL single_ack: got %h expected %h", {done0, p0}, {1'b0, 8'h3F});
        end
    endtask

    task automatic test_extremes();
        logic       sel [3];
        logic [3:0] ta  [3];
        logic [3:0] tb  [3];
        logic [7:0] tp  [3];
        sel = '{1'b1, 1'b0, 1'b0};
        ta  = '{4'd15, 4'd0, 4'd1};
        tb  = '{4'd15, 4'd13, 4'd15};
        tp  = '{8'hE1, 8'h00, 8'h0F};
        for (int i = 0; i < 3; i++) begin
            if (sel[i]) begin a1 = ta[i]; b1 = tb[i]; req1 = 1'b1; end
            else        begin a0 = ta[i]; b0 = tb[i]; req0 = 1'b1; end
            step();
            checks++;
            if ({gnt0, gnt1} !== {~sel[i], sel[i]}) begin
                errors++;
                $display("FAIL extreme_grant[%0d]: gnt0/gnt1 got %b expected %b", i, {gnt0, gnt1}, {~sel[i], sel[i]});
            end
            req0 = 1'b0; req1 = 1'b0;
            step();
            checks++;
            if ((sel[i] ? {done1, p1} : {done0, p0}) !== {1'b1, tp[i]}) begin
                errors++;
                $display("FAIL extreme_product[%0d]: got %h expected %h", i,
                         sel[i] ? {done1, p1} : {done0, p0}, {1'b1, tp[i]});
            end
            ack0 = ~sel[i]; ack1 = sel[i];
            step();
            ack0 = 1'b0; ack1 = 1'b0;
        end
    endtask

    task automatic test_contention();
        int order [$];
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        a0 = 4'd3; b0 = 4'd5; a1 = 4'd6; b1 = 4'd6;
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (gnt0) order.push_back(0);
            if (gnt1) order.push_back(1);
            ack0 = done0; ack1 = done1;
        end
        checks++;
        if (order.size() != 4) begin
            errors++;
            $display("FAIL contention_count: got %0d grants expected 4", order.size());
        end else begin
            checks++;
            if ({order[0], order[1], order[2], order[3]} !== {32'd0, 32'd1, 32'd0, 32'd1}) begin
                errors++;
                $display("FAIL contention_order: got %0d%0d%0d%0d expected 0101", order[0], order[1], order[2], order[3]);
            end
        end
        checks++;
        if ({p0, p1} !== {8'h0F, 8'h24}) begin
            errors++;
            $display("FAIL contention_products: got %h expected 0f24", {p0, p1});
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            ack0 = done0; ack1 = done1;
        end
        ack0 = 1'b0; ack1 = 1'b0;
    endtask

    task automatic test_blocking();
        a1 = 4'd2; b1 = 4'd3; req1 = 1'b1;
        step();
        req1 = 1'b0;
        step();
        checks++;
        if ({done1, p1} !== {1'b1, 8'h06}) begin
            errors++;
            $display("FAIL block_setup: got %h expected 106", {done1, p1});
        end
        req1 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({gnt1, busy} !== 2'b00) begin
                errors++;
                $display("FAIL block_hold[%0d]: gnt1/busy got %b expected 00", c, {gnt1, busy});
            end
        end
        ack1 = 1'b1;
        step();
        ack1 = 1'b0;
        checks++;
        if ({gnt1, done1} !== 2'b00) begin
            errors++;
            $display("FAIL block_ack_edge: gnt1/done1 got %b expected 00", {gnt1, done1});
        end
        step();
        checks++;
        if ({gnt1, busy} !== 2'b11) begin
            errors++;
            $display("FAIL block_regrant: gnt1/busy got %b expected 11", {gnt1, busy});
        end
        req1 = 1'b0;
        step();
        ack1 = 1'b1;
        step();
        ack1 = 1'b0;
    endtask

    task automatic test_settle();
        a0 = 4'd12; b0 = 4'd11; req0_s = 1'b1;
        step();
        req0_s = 1'b0;
        checks++;
        if ({gnt0_s, busy_s, ma_s, mb_s} !== {2'b11, 4'd12, 4'd11}) begin
            errors++;
            $display("FAIL settle_grant: got %h expected %h", {gnt0_s, busy_s, ma_s, mb_s}, {2'b11, 4'd12, 4'd11});
        end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({gnt0_s, busy_s, done0_s, ma_s, mb_s} !== {3'b010, 4'd12, 4'd11}) begin
                errors++;
                $display("FAIL settle_wait[%0d]: got %h expected %h", c, {gnt0_s, busy_s, done0_s, ma_s, mb_s}, {3'b010, 4'd12, 4'd11});
            end
        end
        step();
        checks++;
        if ({busy_s, done0_s, p0_s, ma_s, mb_s} !== {2'b01, 8'h84, 4'd12, 4'd11}) begin
            errors++;
            $display("FAIL settle_done: got %h expected %h", {busy_s, done0_s, p0_s, ma_s, mb_s}, {2'b01, 8'h84, 4'd12, 4'd11});
        end
        ack0 = 1'b1;
        step();
        ack0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        a1 = 4'd4; b1 = 4'd4; req1_s = 1'b1;
        step();
        req1_s = 1'b0;
        repeat (3) step();
        checks++;
        if ({done1_s, p1_s} !== {1'b1, 8'h10}) begin
            errors++;
            $display("FAIL mid_setup: got %h expected 110", {done1_s, p1_s});
        end
        a0 = 4'd9; b0 = 4'd9; req0_s = 1'b1;
        step();
        req0_s = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt0_s, gnt1_s, done0_s, done1_s, busy_s, ma_s, mb_s, p0_s, p1_s} !== 29'd0) begin
            errors++;
            $display("FAIL mid_reset: got %h expected 0", {gnt0_s, gnt1_s, done0_s, done1_s, busy_s, ma_s, mb_s, p0_s, p1_s});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if ({done0_s, done1_s, busy_s} !== 3'b000) begin
                errors++;
                $display("FAIL mid_no_done[%0d]: done0/done1/busy got %b expected 000", c, {done0_s, done1_s, busy_s});
            end
        end
        a1 = 4'd5; b1 = 4'd5; req1_s = 1'b1;
        step();
        req1_s = 1'b0;
        checks++;
        if ({gnt0_s, gnt1_s} !== 2'b01) begin
            errors++;
            $display("FAIL mid_regrant: gnt0/gnt1 got %b expected 01", {gnt0_s, gnt1_s});
        end
        repeat (3) step();
        checks++;
        if ({done1_s, p1_s} !== {1'b1, 8'h19}) begin
            errors++;
            $display("FAIL mid_product: got %h expected 119", {done1_s, p1_s});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_contention();
        test_blocking();
        test_settle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
